// File: rtl/ctrl_pipe_reg.sv
// Control-bundle pipeline register: carries decode control bits, a valid bit and a payload through STAGES registers.
// Latency: STAGES cycles from input capture to output; outputs are driven purely from registered state.
// Backpressure: STALL freezes every stage, BUBBLE injects a NOP at stage 0, FLUSH kills all stages and drops the input.
module ctrl_pipe_reg #(
  parameter int STAGES = 1,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_VALID,
  input  logic [1:0]        IN_ALUOp,
  input  logic              IN_ALUSrc,
  input  logic              IN_Branch,
  input  logic              IN_MemRead,
  input  logic              IN_MemWrite,
  input  logic              IN_RegWrite,
  input  logic              IN_MemToReg,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              STALL,
  input  logic              BUBBLE,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  output logic [1:0]        OUT_ALUOp,
  output logic              OUT_ALUSrc,
  output logic              OUT_Branch,
  output logic              OUT_MemRead,
  output logic              OUT_MemWrite,
  output logic              OUT_RegWrite,
  output logic              OUT_MemToReg,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [2:0]        OUT_OCC,
  output logic [CNT_W-1:0]  OUT_BUBBLES
);

  // Control bundle carried alongside each instruction.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam int LAST = STAGES - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Per-stage state.
  logic              stg_vld  [STAGES];
  ctrl_t             stg_ctrl [STAGES];
  logic [DATA_W-1:0] stg_dat  [STAGES];

  logic [CNT_W-1:0]  bubble_cnt;
  ctrl_t             in_ctrl;
  ctrl_t             out_ctrl;
  logic [2:0]        occ;

  // Gather the loose input control bits into one bundle.
  assign in_ctrl = '{
    alu_op:     IN_ALUOp,
    alu_src:    IN_ALUSrc,
    branch:     IN_Branch,
    mem_read:   IN_MemRead,
    mem_write:  IN_MemWrite,
    reg_write:  IN_RegWrite,
    mem_to_reg: IN_MemToReg
  };

  // Stage registers: reset > flush > stall > bubble > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_vld[k]  <= 1'b0;
        stg_ctrl[k] <= '0;
        stg_dat[k]  <= '0;
      end
    end else if (FLUSH) begin
      // Payloads are left in place; only valid and control are killed.
      for (int k = 0; k < STAGES; k++) begin
        stg_vld[k]  <= 1'b0;
        stg_ctrl[k] <= '0;
      end
    end else if (!STALL) begin
      if (BUBBLE) begin
        // NOP in stage 0; its payload is held rather than loaded.
        stg_vld[0]  <= 1'b0;
        stg_ctrl[0] <= '0;
      end else begin
        // Control is captured even for invalid slots; gating happens at the output.
        stg_vld[0]  <= IN_VALID;
        stg_ctrl[0] <= in_ctrl;
        stg_dat[0]  <= IN_DATA;
      end
      for (int k = 1; k < STAGES; k++) begin
        stg_vld[k]  <= stg_vld[k-1];
        stg_ctrl[k] <= stg_ctrl[k-1];
        stg_dat[k]  <= stg_dat[k-1];
      end
    end
  end

  // Saturating bubble counter; only a bubble that actually enters the pipe is counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!FLUSH && !STALL && BUBBLE && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  // Occupancy: number of stages currently holding a real instruction.
  always_comb begin
    occ = 3'd0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + {2'b00, stg_vld[k]};
    end
  end

  // Invalid slots never present live control to downstream stages.
  assign out_ctrl = stg_ctrl[LAST] & {$bits(ctrl_t){stg_vld[LAST]}};

  assign OUT_VALID    = stg_vld[LAST];
  assign OUT_ALUOp    = out_ctrl.alu_op;
  assign OUT_ALUSrc   = out_ctrl.alu_src;
  assign OUT_Branch   = out_ctrl.branch;
  assign OUT_MemRead  = out_ctrl.mem_read;
  assign OUT_MemWrite = out_ctrl.mem_write;
  assign OUT_RegWrite = out_ctrl.reg_write;
  assign OUT_MemToReg = out_ctrl.mem_to_reg;
  assign OUT_DATA     = stg_dat[LAST];
  assign OUT_OCC      = occ;
  assign OUT_BUBBLES  = bubble_cnt;

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Directed bench for ctrl_pipe_reg: three instances (STAGES=3, 2, 4/CNT_W=4) share one stimulus stream.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: STALL/BUBBLE/FLUSH driven directly as directed vectors.
module tb_ctrl_pipe_reg;

  logic        clk;
  logic        rst;
  logic        in_vld;
  logic [7:0]  in_ctrl;   // {alu_op[1:0], alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg}
  logic [31:0] in_dat;
  logic        stall;
  logic        bubble;
  logic        flush;

  logic        v3, v2, v4;
  logic [1:0]  aop3, aop2, aop4;
  logic        as3, br3, mr3, mw3, rw3, m2r3;
  logic        as2, br2, mr2, mw2, rw2, m2r2;
  logic        as4, br4, mr4, mw4, rw4, m2r4;
  logic [31:0] d3, d2, d4;
  logic [2:0]  occ3, occ2, occ4;
  logic [15:0] cnt3, cnt2;
  logic [3:0]  cnt4;

  wire [7:0] c3 = {aop3, as3, br3, mr3, mw3, rw3, m2r3};
  wire [7:0] c2 = {aop2, as2, br2, mr2, mw2, rw2, m2r2};
  wire [7:0] c4 = {aop4, as4, br4, mr4, mw4, rw4, m2r4};

  int total = 0;
  int bad   = 0;

  ctrl_pipe_reg #(.STAGES(3), .DATA_W(32), .CNT_W(16)) u_s3 (
    .clk(clk), .rst(rst), .IN_VALID(in_vld), .IN_ALUOp(in_ctrl[7:6]),
    .IN_ALUSrc(in_ctrl[5]), .IN_Branch(in_ctrl[4]), .IN_MemRead(in_ctrl[3]),
    .IN_MemWrite(in_ctrl[2]), .IN_RegWrite(in_ctrl[1]), .IN_MemToReg(in_ctrl[0]),
    .IN_DATA(in_dat), .STALL(stall), .BUBBLE(bubble), .FLUSH(flush),
    .OUT_VALID(v3), .OUT_ALUOp(aop3), .OUT_ALUSrc(as3), .OUT_Branch(br3),
    .OUT_MemRead(mr3), .OUT_MemWrite(mw3), .OUT_RegWrite(rw3), .OUT_MemToReg(m2r3),
    .OUT_DATA(d3), .OUT_OCC(occ3), .OUT_BUBBLES(cnt3)
  );

  ctrl_pipe_reg #(.STAGES(2), .DATA_W(32), .CNT_W(16)) u_s2 (
    .clk(clk), .rst(rst), .IN_VALID(in_vld), .IN_ALUOp(in_ctrl[7:6]),
    .IN_ALUSrc(in_ctrl[5]), .IN_Branch(in_ctrl[4]), .IN_MemRead(in_ctrl[3]),
    .IN_MemWrite(in_ctrl[2]), .IN_RegWrite(in_ctrl[1]), .IN_MemToReg(in_ctrl[0]),
    .IN_DATA(in_dat), .STALL(stall), .BUBBLE(bubble), .FLUSH(flush),
    .OUT_VALID(v2), .OUT_ALUOp(aop2), .OUT_ALUSrc(as2), .OUT_Branch(br2),
    .OUT_MemRead(mr2), .OUT_MemWrite(mw2), .OUT_RegWrite(rw2), .OUT_MemToReg(m2r2),
    .OUT_DATA(d2), .OUT_OCC(occ2), .OUT_BUBBLES(cnt2)
  );

  ctrl_pipe_reg #(.STAGES(4), .DATA_W(32), .CNT_W(4)) u_s4 (
    .clk(clk), .rst(rst), .IN_VALID(in_vld), .IN_ALUOp(in_ctrl[7:6]),
    .IN_ALUSrc(in_ctrl[5]), .IN_Branch(in_ctrl[4]), .IN_MemRead(in_ctrl[3]),
    .IN_MemWrite(in_ctrl[2]), .IN_RegWrite(in_ctrl[1]), .IN_MemToReg(in_ctrl[0]),
    .IN_DATA(in_dat), .STALL(stall), .BUBBLE(bubble), .FLUSH(flush),
    .OUT_VALID(v4), .OUT_ALUOp(aop4), .OUT_ALUSrc(as4), .OUT_Branch(br4),
    .OUT_MemRead(mr4), .OUT_MemWrite(mw4), .OUT_RegWrite(rw4), .OUT_MemToReg(m2r4),
    .OUT_DATA(d4), .OUT_OCC(occ4), .OUT_BUBBLES(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] d);
    in_vld  = v;
    in_ctrl = c;
    in_dat  = d;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; bubble = 1'b0; flush = 1'b0;
    drive(1'b0, 8'h00, 32'h0);

    // ---- reset with noisy inputs, then latency on STAGES=3 ----
    drive(1'b1, 8'hFF, 32'hFF);
    bubble = 1'b1;
    tick();
    chk("rst_vld",  {31'b0, v3}, 32'd0);
    chk("rst_ctrl", {24'b0, c3}, 32'd0);
    tick();
    chk("rst_dat",  d3, 32'd0);
    chk("rst_occ",  {29'b0, occ3}, 32'd0);
    chk("rst_cnt",  {16'b0, cnt3}, 32'd0);
    chk("rst_cnt4", {28'b0, cnt4}, 32'd0);
    rst = 1'b0; bubble = 1'b0;
    drive(1'b1, 8'h02, 32'hA5);          // RegWrite
    tick();                               // capture edge N
    drive(1'b0, 8'h00, 32'h0);
    chk("lat_n0_vld", {31'b0, v3}, 32'd0);
    tick();
    chk("lat_n1_vld", {31'b0, v3}, 32'd0);
    tick();
    chk("lat_n2_vld",  {31'b0, v3}, 32'd1);
    chk("lat_n2_ctrl", {24'b0, c3}, 32'h02);
    chk("lat_n2_dat",  d3, 32'hA5);
    chk("lat_n2_occ",  {29'b0, occ3}, 32'd1);

    // ---- stall on STAGES=2 ----
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b1, 8'h08, 32'h11); tick();   // I1 MemRead
    drive(1'b1, 8'h02, 32'h22); tick();   // I2 RegWrite
    chk("stall_pre_dat", d2, 32'h11);
    chk("stall_pre_occ", {29'b0, occ2}, 32'd2);
    stall = 1'b1;
    drive(1'b1, 8'h04, 32'h33);           // must never appear
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_dat",  d2, 32'h11);
      chk("stall_ctrl", {24'b0, c2}, 32'h08);
      chk("stall_occ",  {29'b0, occ2}, 32'd2);
    end
    stall = 1'b0;
    drive(1'b0, 8'h00, 32'h44);
    tick();
    chk("resume1_dat",  d2, 32'h22);
    chk("resume1_ctrl", {24'b0, c2}, 32'h02);
    chk("resume1_occ",  {29'b0, occ2}, 32'd1);
    tick();
    chk("resume2_dat", d2, 32'h44);
    chk("resume2_vld", {31'b0, v2}, 32'd0);
    chk("resume2_occ", {29'b0, occ2}, 32'd0);

    // ---- bubble on STAGES=2 with MemWrite stream ----
    rst = 1'b1; tick(); rst = 1'b0;
    drive(1'b1, 8'h04, 32'h50); tick();
    drive(1'b1, 8'h04, 32'h51); tick();
    chk("bub_pre_dat", d2, 32'h50);
    bubble = 1'b1;
    drive(1'b1, 8'h04, 32'h52); tick();   // bubble inserted here
    chk("bub_c_dat", d2, 32'h51);
    chk("bub_c_vld", {31'b0, v2}, 32'd1);
    chk("bub_cnt1",  {16'b0, cnt2}, 32'd1);
    bubble = 1'b0;
    drive(1'b1, 8'h04, 32'h53); tick();
    chk("bub_out_vld",  {31'b0, v2}, 32'd0);
    chk("bub_out_mw",   {31'b0, mw2}, 32'd0);
    chk("bub_out_dat",  d2, 32'h51);
    drive(1'b1, 8'h04, 32'h54); tick();
    chk("bub_after_dat",  d2, 32'h53);
    chk("bub_after_ctrl", {24'b0, c2}, 32'h04);
    stall = 1'b1; bubble = 1'b1; tick();
    chk("bub_stall_cnt", {16'b0, cnt2}, 32'd1);
    chk("bub_stall_dat", d2, 32'h53);
    stall = 1'b0; bubble = 1'b0;

    // ---- flush on STAGES=4 ----
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h20, 32'h60 + i);
      tick();
    end
    chk("fl_pre_occ", {29'b0, occ4}, 32'd4);
    chk("fl_pre_dat", d4, 32'h60);
    flush = 1'b1;
    drive(1'b1, 8'h20, 32'h64);
    tick();                               // flush edge N
    chk("fl_occ",  {29'b0, occ4}, 32'd0);
    chk("fl_vld",  {31'b0, v4}, 32'd0);
    chk("fl_ctrl", {24'b0, c4}, 32'd0);
    chk("fl_dat",  d4, 32'h60);
    chk("fl_cnt",  {28'b0, cnt4}, 32'd0);
    flush = 1'b0;
    drive(1'b1, 8'h01, 32'h70);
    tick();                               // N+1 captures
    drive(1'b0, 8'h00, 32'h0);
    chk("fl_n1_vld", {31'b0, v4}, 32'd0);
    tick();
    chk("fl_n2_vld", {31'b0, v4}, 32'd0);
    tick();
    chk("fl_n3_vld", {31'b0, v4}, 32'd0);
    tick();
    chk("fl_n4_vld",  {31'b0, v4}, 32'd1);
    chk("fl_n4_dat",  d4, 32'h70);
    chk("fl_n4_ctrl", {24'b0, c4}, 32'h01);

    // ---- counter saturation, CNT_W=4 on u_s4 ----
    rst = 1'b1; tick(); rst = 1'b0;
    bubble = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 13) chk("sat_cnt14", {28'b0, cnt4}, 32'd14);
    end
    chk("sat_cnt15", {28'b0, cnt4}, 32'd15);
    chk("nosat_cnt20", {16'b0, cnt2}, 32'd20);
    bubble = 1'b0; flush = 1'b1; tick();
    chk("sat_flush", {28'b0, cnt4}, 32'd15);
    flush = 1'b0; rst = 1'b1; tick();
    chk("sat_rst", {28'b0, cnt4}, 32'd0);
    rst = 1'b0;

    // ---- invalid slot gating on STAGES=3 ----
    drive(1'b0, 8'hFF, 32'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gate_ctrl", {24'b0, c3}, 32'd0);
      chk("gate_vld",  {31'b0, v3}, 32'd0);
    end
    chk("gate_dat", d3, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
